alu_driver: RTL and testbench
=============================

Name: alu_driver

Overview:
- Command front-end that sits upstream of the team ALU and owns its operand/control/enable interface.
- Accepts one operation request at a time through a valid/ready handshake and drives A, B, control and enable to the ALU for the number of cycles the ALU pipeline needs.
- Captures the ALU result and flags, normalises the flag polarity, and returns them through a valid/ready response channel.
- Also counts completed operations.

Parameters:
- LENGTH_v, 5, operand width; ALU result width is 2*LENGTH_v.
- SETTLE_CYCLES, 3, cycles alu_enable is held high per operation (covers the ALU's result_temp stage, result stage and lagging zero flag); legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  driver can accept a request.
- req_op  input  4  ALU control code; 0..9 legal.
- req_a  input  LENGTH_v  signed operand A.
- req_b  input  LENGTH_v  signed operand B.
- alu_A  output  LENGTH_v  to ALU A.
- alu_B  output  LENGTH_v  to ALU B.
- alu_control  output  4  to ALU control.
- alu_enable  output  1  to ALU enable.
- alu_result  input  2*LENGTH_v  from ALU result.
- alu_carry, alu_overflow, alu_negative, alu_zero  input  1 each  from ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  2*LENGTH_v  captured result.
- rsp_flags  output  4  {carry, overflow, negative, zero}; negative=1 means the result is negative.
- rsp_error  output  1  illegal opcode; ALU not exercised.
- op_count  output  8  completed responses, wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - alu_A=0, alu_B=0, alu_control=0, alu_enable=0.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_error=0, op_count=0.
  - The internal settle counter is 0.
  - Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, DRIVE, CAPTURE, RESPOND.
- IDLE:
  - req_ready=1; all other states have req_ready=0.
  - On req_valid&&req_ready, register req_a/req_b/req_op onto alu_A/alu_B/alu_control.
  - If req_op<=9, go to DRIVE.
  - If req_op>9: set rsp_error=1, rsp_result=0, rsp_flags=0, and go directly to RESPOND. alu_enable stays 0.
- DRIVE:
  - alu_enable=1 for exactly SETTLE_CYCLES consecutive cycles.
  - Operands and control are held stable throughout.
  - The counter counts 0..SETTLE_CYCLES-1; on the last count go to CAPTURE.
- CAPTURE (1 cycle):
  - alu_enable=0, so the ALU holds its outputs.
  - Register rsp_result=alu_result, carry=alu_carry, overflow=alu_overflow, zero=alu_zero.
  - negative=~alu_negative for op<=3, otherwise 0 (the ALU drives negative=1 for non-negative results).
  - rsp_error=0. Go to RESPOND.
- RESPOND:
  - rsp_valid=1; rsp_* are stable while rsp_valid&&!rsp_ready.
  - On rsp_ready: rsp_valid drops next cycle, op_count increments (255 wraps to 0), state returns to IDLE.
- Latency for a legal op, accept edge to rsp_valid high: SETTLE_CYCLES+2 cycles. Illegal op: 1 cycle.
- Back-to-back: the earliest next accept is the cycle after the response handshake. No overlap and no request queueing.
- req_valid deasserting while not ready is ignored; a request is taken only on the handshake edge.
- rsp_ready held high before rsp_valid is legal; the handshake completes on the first rsp_valid cycle.
- Outputs hold their last values in IDLE, except alu_enable=0 and rsp_valid=0.

Decomposition:
- Shared package alu_pkg:
  - The ten opcode constants (ADD=0 .. SHR=9).
  - OP_LAST=9.
  - Flag bit indices CARRY=3, OVF=2, NEG=1, ZERO=0.
  - State enum for alu_driver.
- No sub-module is needed; the settle counter and FSM live in one module.

Test Plan:
- Reset then ADD with req_a=3, req_b=4, against the ALU instance:
  - alu_enable is high exactly 3 cycles.
  - rsp_valid rises 5 cycles after accept.
  - rsp_result=7, rsp_flags=4'b0000, rsp_error=0, op_count=1.
- SUB with req_a=2, req_b=5:
  - rsp_flags[NEG]=1, rsp_result=3 (the ALU returns the magnitude).
  - rsp_flags[ZERO]=0.
- Illegal op=4'b1100:
  - rsp_valid rises 1 cycle after accept; alu_enable never rises.
  - rsp_error=1, rsp_result=0.
- Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid:
  - rsp_* stay stable and req_ready stays 0.
  - Then rsp_ready=1 for 1 cycle: rsp_valid=0 and req_ready=1 the next cycle.
- Reset pulse during DRIVE (2nd enable cycle):
  - alu_enable=0 immediately (asynchronous).
  - No rsp_valid, op_count=0; the next request completes normally.
- 256 back-to-back AND ops (A=5'b01111, B=5'b00101):
  - Each rsp_result=5.
  - op_count wraps to 0 after the 256th handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices and driver FSM states for the ALU front-end.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    localparam logic [3:0] OP_LAST = OP_SHR;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESPOND = 2'd3
    } drv_state_t;

endpackage

// File: rtl/alu_driver.sv
// Request/response front-end that sequences one ALU operation at a time
// and returns the captured result with normalised flags.
module alu_driver
    import alu_pkg::*;
#(
    parameter int LENGTH_v      = 5,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [LENGTH_v-1:0]   req_a,
    input  logic [LENGTH_v-1:0]   req_b,
    output logic [LENGTH_v-1:0]   alu_A,
    output logic [LENGTH_v-1:0]   alu_B,
    output logic [3:0]            alu_control,
    output logic                  alu_enable,
    input  logic [2*LENGTH_v-1:0] alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*LENGTH_v-1:0] rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_error,
    output logic [7:0]            op_count
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    drv_state_t r_state;
    drv_state_t w_next;

    logic [3:0]            r_cnt;
    logic [LENGTH_v-1:0]   r_a;
    logic [LENGTH_v-1:0]   r_b;
    logic [3:0]            r_ctrl;
    logic [2*LENGTH_v-1:0] r_res;
    logic [3:0]            r_flags;
    logic                  r_err;
    logic [7:0]            r_ops;

    logic w_accept;
    logic w_illegal;
    logic w_cnt_done;
    logic w_rsp_done;
    logic w_neg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        alu_enable = 1'b0;
        rsp_valid  = 1'b0;
        w_accept   = 1'b0;
        w_rsp_done = 1'b0;
        w_illegal  = (req_op > OP_LAST);
        w_cnt_done = (r_cnt == CNT_LAST);
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                w_accept  = req_valid;
                if (req_valid) begin
                    w_next = w_illegal ? S_RESPOND : S_DRIVE;
                end
            end
            S_DRIVE: begin
                alu_enable = 1'b1;
                if (w_cnt_done) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = S_RESPOND;
            end
            S_RESPOND: begin
                rsp_valid  = 1'b1;
                w_rsp_done = rsp_ready;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The ALU reports negative=1 for non-negative arithmetic results.
    assign w_neg = (r_ctrl <= OP_DIV) ? ~alu_negative : 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_DRIVE) begin
            r_cnt <= w_cnt_done ? 4'd0 : r_cnt + 4'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ctrl  <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a    <= req_a;
            r_b    <= req_b;
            r_ctrl <= req_op;
            if (w_illegal) begin
                r_err   <= 1'b1;
                r_res   <= '0;
                r_flags <= '0;
            end
        end else if (r_state == S_CAPTURE) begin
            r_res                <= alu_result;
            r_flags[FLAG_CARRY]  <= alu_carry;
            r_flags[FLAG_OVF]    <= alu_overflow;
            r_flags[FLAG_NEG]    <= w_neg;
            r_flags[FLAG_ZERO]   <= alu_zero;
            r_err                <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ops <= '0;
        end else if (w_rsp_done) begin
            r_ops <= r_ops + 8'd1;
        end
    end

    assign alu_A       = r_a;
    assign alu_B       = r_b;
    assign alu_control = r_ctrl;
    assign rsp_result  = r_res;
    assign rsp_flags   = r_flags;
    assign rsp_error   = r_err;
    assign op_count    = r_ops;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a small pipelined ALU stand-in.
module tb_alu_driver;
    import alu_pkg::*;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [4:0] req_a;
    logic [4:0] req_b;
    logic [4:0] alu_A;
    logic [4:0] alu_B;
    logic [3:0] alu_control;
    logic       alu_enable;
    logic [9:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_negative;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [9:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       rsp_error;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    alu_driver #(.LENGTH_v(5), .SETTLE_CYCLES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_control  (alu_control),
        .alu_enable   (alu_enable),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_error    (rsp_error),
        .op_count     (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU stand-in: temp stage, result stage, zero lags one more stage.
    logic [5:0] w_sum;
    logic [5:0] w_dif;
    logic [5:0] w_mag;
    logic [9:0] w_res;
    logic       w_c;
    logic       w_o;
    logic       w_n;
    logic [9:0] m_res;
    logic       m_c;
    logic       m_o;
    logic       m_n;

    always_comb begin
        w_sum = {alu_A[4], alu_A} + {alu_B[4], alu_B};
        w_dif = {alu_A[4], alu_A} - {alu_B[4], alu_B};
        w_mag = w_dif[5] ? (6'd0 - w_dif) : w_dif;
        w_res = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        w_n   = 1'b0;
        case (alu_control)
            OP_ADD: begin
                w_res = {{4{w_sum[5]}}, w_sum};
                w_c   = ({1'b0, alu_A} + {1'b0, alu_B}) > 6'd31;
                w_o   = w_sum[5] ^ w_sum[4];
                w_n   = ~w_sum[5];
            end
            OP_SUB: begin
                w_res = {4'd0, w_mag};
                w_n   = ~w_dif[5];
            end
            OP_AND: w_res = {5'd0, alu_A & alu_B};
            default: w_res = '0;
        endcase
    end

    always @(posedge clock) begin
        if (alu_enable) begin
            m_res        <= w_res;
            m_c          <= w_c;
            m_o          <= w_o;
            m_n          <= w_n;
            alu_result   <= m_res;
            alu_carry    <= m_c;
            alu_overflow <= m_o;
            alu_negative <= m_n;
            alu_zero     <= (alu_result == 10'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [3:0] op, input logic [4:0] a,
                          input logic [4:0] b);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 4'hf;
    endtask

    task automatic wait_rsp(output int lat, output int en);
        lat = 1;
        en  = 0;
        while (!rsp_valid && lat < 40) begin
            if (alu_enable) en++;
            @(posedge clock);
            #1;
            lat++;
        end
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [4:0] a, input logic [4:0] b,
                          input logic [9:0] e_res, input logic [3:0] e_flg);
        int lat;
        int en;
        accept(op, a, b);
        wait_rsp(lat, en);
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_en"}, 32'(en), 32'd3);
        check({tag, "_res"}, 32'(rsp_result), 32'(e_res));
        check({tag, "_flags"}, 32'(rsp_flags), 32'(e_flg));
        check({tag, "_err"}, 32'(rsp_error), 32'd0);
        handshake();
    endtask

    initial begin
        int lat;
        int en;
        logic seen;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 5'd0;
        req_b     = 5'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_A", 32'(alu_A), 32'd0);
        check("rst_B", 32'(alu_B), 32'd0);
        check("rst_ctrl", 32'(alu_control), 32'd0);
        check("rst_en", 32'(alu_enable), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_res", 32'(rsp_result), 32'd0);
        check("rst_flags", 32'(rsp_flags), 32'd0);
        check("rst_err", 32'(rsp_error), 32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("idle_ready", 32'(req_ready), 32'd1);

        run_op("add_3_4", OP_ADD, 5'd3, 5'd4, 10'd7, 4'b0000);
        check("cnt_1", 32'(op_count), 32'd1);
        check("idle_valid_low", 32'(rsp_valid), 32'd0);
        run_op("sub_2_5", OP_SUB, 5'd2, 5'd5, 10'd3, 4'b0010);
        run_op("add_ovf", OP_ADD, 5'd15, 5'd15, 10'd30, 4'b0100);
        run_op("add_carry_zero", OP_ADD, 5'b11111, 5'd1, 10'd0, 4'b1001);
        check("cnt_4", 32'(op_count), 32'd4);

        accept(4'b1100, 5'd7, 5'd9);
        wait_rsp(lat, en);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_en", 32'(en), 32'd0);
        check("ill_err", 32'(rsp_error), 32'd1);
        check("ill_res", 32'(rsp_result), 32'd0);
        check("ill_flags", 32'(rsp_flags), 32'd0);
        handshake();
        check("ill_en_after", 32'(alu_enable), 32'd0);
        check("cnt_5", 32'(op_count), 32'd5);

        accept(OP_ADD, 5'd1, 5'd2);
        wait_rsp(lat, en);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check("bp_hold", {rsp_valid, req_ready, rsp_error, rsp_flags,
                              rsp_result}, {1'b1, 1'b0, 1'b0, 4'd0, 10'd3});
        end
        handshake();
        check("bp_valid_drop", 32'(rsp_valid), 32'd0);
        check("bp_ready_back", 32'(req_ready), 32'd1);
        check("cnt_6", 32'(op_count), 32'd6);

        accept(OP_ADD, 5'd6, 5'd6);
        @(posedge clock);
        #1;
        check("drive_en2", 32'(alu_enable), 32'd1);
        reset = 1'b0;
        #1;
        check("async_en", 32'(alu_enable), 32'd0);
        check("async_cnt", 32'(op_count), 32'd0);
        check("async_ready", 32'(req_ready), 32'd1);
        #2;
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            seen = seen | rsp_valid | alu_enable;
        end
        check("abandoned", 32'(seen), 32'd0);

        rsp_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            accept(OP_AND, 5'b01111, 5'b00101);
            wait_rsp(lat, en);
            check("and_res", 32'(rsp_result), 32'd5);
            @(posedge clock);
            #1;
            if (k == 0) begin
                check("and_lat", 32'(lat), 32'd5);
                check("and_flags", 32'(rsp_flags), 32'd0);
                check("and_cnt_1", 32'(op_count), 32'd1);
            end
            if (k == 254) check("and_cnt_255", 32'(op_count), 32'd255);
        end
        rsp_ready = 1'b0;
        check("wrap_cnt", 32'(op_count), 32'd0);
        check("wrap_valid", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
